// File: rtl/mig_cmd_scheduler.sv
// mig_cmd_scheduler: registered owner-grant scheduler for the single MIG DDR2
// command/address FIFO, shared by the write-burst and read-burst engines.
// One engine owns the FIFO per burst. Every release passes through one dead
// TURN cycle and one IDLE cycle before the next grant. Reads win ties until
// MAX_RD_RUN consecutive reads have blocked a pending write.
//
// Optional feature: define SCHED_WATCHDOG_EN to enable a per-grant watchdog.
// A grant lasting TIMEOUT cycles is force-released and sets sticky sched_err.
//
// Ports:
//   clk, reset (async, active-low), phy_init_done  - clock, reset, MIG calibrated
//   wr_req/wr_cmd/wr_addr/wr_af_we/wr_done          - write engine side
//   rd_req/rd_cmd/rd_addr/rd_af_we/rd_done          - read engine side
//   wr_gnt, rd_gnt                                  - registered ownership grants
//   cmd, address, af_we                             - to MIG app_cmd/app_addr/app_af_wren
//   sched_err                                       - sticky watchdog error
module mig_cmd_scheduler #(
  parameter int unsigned ADDR_W     = 31,
  parameter int unsigned MAX_RD_RUN = 4,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              phy_init_done,
  input  logic              wr_req,
  input  logic [2:0]        wr_cmd,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_af_we,
  input  logic              wr_done,
  input  logic              rd_req,
  input  logic [2:0]        rd_cmd,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_af_we,
  input  logic              rd_done,
  output logic              wr_gnt,
  output logic              rd_gnt,
  output logic [2:0]        cmd,
  output logic [ADDR_W-1:0] address,
  output logic              af_we,
  output logic              sched_err
);

  localparam int unsigned RunW = $clog2(MAX_RD_RUN + 1);

  typedef enum logic [2:0] {StWaitInit, StIdle, StRdOwn, StWrOwn, StTurn} state_e;

  state_e            state_q, state_d;
  logic [RunW-1:0]   rd_run_q, rd_run_d;
  logic              rd_gnt_q, wr_gnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              timeout;
  logic              rd_release, wr_release;

`ifdef SCHED_WATCHDOG_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q;
  logic            err_q;
  logic            owning;

  assign owning  = (state_q == StRdOwn) || (state_q == StWrOwn);
  // Fires in the TIMEOUT-th owning cycle so the grant lasts exactly TIMEOUT cycles.
  assign timeout = owning && (cnt_q == CntW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      // Only IDLE leads into an owning state, so the count is zero on entry.
      cnt_q <= owning ? cnt_q + CntW'(1) : '0;
      err_q <= err_q | timeout;
    end
  end

  assign sched_err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout       = 1'b0;
  assign sched_err     = 1'b0;
`endif

  // Done pulses from the non-owner never reach the FSM.
  assign rd_release = (state_q == StRdOwn) && (rd_done || timeout);
  assign wr_release = (state_q == StWrOwn) && (wr_done || timeout);

  always_comb begin
    state_d  = state_q;
    rd_run_d = rd_run_q;
    unique case (state_q)
      StWaitInit: if (phy_init_done) state_d = StIdle;
      StIdle: begin
        if (!phy_init_done) begin
          state_d = StWaitInit;
        end else if (rd_req && (!wr_req || (rd_run_q < RunW'(MAX_RD_RUN)))) begin
          state_d = StRdOwn;
        end else if (wr_req) begin
          state_d = StWrOwn;
        end
      end
      StRdOwn: begin
        if (rd_release) begin
          state_d = StTurn;
          if (rd_run_q != RunW'(MAX_RD_RUN)) rd_run_d = rd_run_q + RunW'(1);
        end
      end
      StWrOwn: begin
        if (wr_release) begin
          state_d  = StTurn;
          rd_run_d = '0;
        end
      end
      StTurn:  state_d = phy_init_done ? StIdle : StWaitInit;
      default: state_d = StWaitInit;
    endcase
    // The run only counts reads that actually held off a waiting write.
    if ((state_d == StIdle) && (state_q != StIdle) && !wr_req) rd_run_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StWaitInit;
      rd_run_q <= '0;
      rd_gnt_q <= 1'b0;
      wr_gnt_q <= 1'b0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      rd_run_q <= rd_run_d;
      rd_gnt_q <= (state_d == StRdOwn);
      wr_gnt_q <= (state_d == StWrOwn);
      addr_q   <= address;
    end
  end

  // Steered from the grant flops only, so a non-granted strobe can never leak.
  always_comb begin
    cmd     = '0;
    address = addr_q;
    af_we   = 1'b0;
    if (rd_gnt_q) begin
      cmd     = rd_cmd;
      address = rd_addr;
      af_we   = rd_af_we;
    end else if (wr_gnt_q) begin
      cmd     = wr_cmd;
      address = wr_addr;
      af_we   = wr_af_we;
    end
  end

  assign rd_gnt = rd_gnt_q;
  assign wr_gnt = wr_gnt_q;

endmodule

// File: tb/tb_mig_cmd_scheduler.sv
// Directed self-checking bench for mig_cmd_scheduler (default build).
module tb_mig_cmd_scheduler;

  logic        clk = 1'b0;
  logic        reset, phy_init_done;
  logic        wr_req, wr_af_we, wr_done, rd_req, rd_af_we, rd_done;
  logic [2:0]  wr_cmd, rd_cmd, cmd;
  logic [30:0] wr_addr, rd_addr, address;
  logic        wr_gnt, rd_gnt, af_we, sched_err;

  int checks   = 0;
  int failures = 0;

  mig_cmd_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .phy_init_done (phy_init_done),
    .wr_req        (wr_req),
    .wr_cmd        (wr_cmd),
    .wr_addr       (wr_addr),
    .wr_af_we      (wr_af_we),
    .wr_done       (wr_done),
    .rd_req        (rd_req),
    .rd_cmd        (rd_cmd),
    .rd_addr       (rd_addr),
    .rd_af_we      (rd_af_we),
    .rd_done       (rd_done),
    .wr_gnt        (wr_gnt),
    .rd_gnt        (rd_gnt),
    .cmd           (cmd),
    .address       (address),
    .af_we         (af_we),
    .sched_err     (sched_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Entered with a fresh grant visible; checks it, holds it, releases it and
  // checks the TURN and IDLE gap. Returns on the edge that shows the next grant.
  task automatic burst(input bit is_wr, input string tag);
    chk({tag, "_wr_gnt"}, 32'(wr_gnt), 32'(is_wr));
    chk({tag, "_rd_gnt"}, 32'(rd_gnt), 32'(!is_wr));
    chk({tag, "_cmd"}, 32'(cmd), is_wr ? 32'h2 : 32'h1);
    chk({tag, "_af_we"}, 32'(af_we), 32'h1);
    repeat (4) tick();
    if (is_wr) wr_done = 1'b1;
    else rd_done = 1'b1;
    tick();
    wr_done = 1'b0;
    rd_done = 1'b0;
    #1;
    chk({tag, "_turn_gnt"}, 32'({wr_gnt, rd_gnt}), 32'h0);
    chk({tag, "_turn_cmd"}, 32'({cmd, af_we}), 32'h0);
    chk({tag, "_turn_addr"}, 32'(address), is_wr ? 32'h200 : 32'h100);
    tick();
    chk({tag, "_idle_gnt"}, 32'({wr_gnt, rd_gnt}), 32'h0);
    tick();
  endtask

  initial begin
    reset = 1'b0; phy_init_done = 1'b0;
    wr_req = 1'b0; wr_af_we = 1'b0; wr_done = 1'b0; wr_cmd = 3'b010; wr_addr = 31'h200;
    rd_req = 1'b1; rd_af_we = 1'b0; rd_done = 1'b0; rd_cmd = 3'b001; rd_addr = 31'h100;
    #1;
    chk("rst_gnt", 32'({wr_gnt, rd_gnt}), 32'h0);
    chk("rst_cmd", 32'(cmd), 32'h0);
    chk("rst_addr", 32'(address), 32'h0);
    chk("rst_af_we", 32'(af_we), 32'h0);
    chk("rst_err", 32'(sched_err), 32'h0);
    tick();
    reset = 1'b1;

    // Requests before calibration are held off.
    repeat (8) tick();
    chk("init_gate", 32'(rd_gnt), 32'h0);
    phy_init_done = 1'b1;
    tick();
    chk("init_idle", 32'(rd_gnt), 32'h0);
    tick();
    chk("init_gnt", 32'(rd_gnt), 32'h1);
    chk("init_cmd", 32'(cmd), 32'h1);
    chk("init_addr", 32'(address), 32'h100);

    // Write-side strobe and address must not leak during a read grant.
    wr_af_we = 1'b1; wr_addr = 31'hABC; rd_af_we = 1'b0;
    #1;
    chk("iso_af_we0", 32'(af_we), 32'h0);
    chk("iso_addr0", 32'(address), 32'h100);
    rd_af_we = 1'b1;
    #1;
    chk("iso_af_we1", 32'(af_we), 32'h1);
    tick();
    chk("iso_addr1", 32'(address), 32'h100);
    wr_addr = 31'h200;

    // Both requesting: R,R,R,R,W,R,R,R,R,W then R again.
    wr_req = 1'b1;
    burst(1'b0, "g0"); burst(1'b0, "g1"); burst(1'b0, "g2"); burst(1'b0, "g3");
    burst(1'b1, "g4");
    burst(1'b0, "g5"); burst(1'b0, "g6"); burst(1'b0, "g7"); burst(1'b0, "g8");
    burst(1'b1, "g9");
    chk("g10_rd_gnt", 32'(rd_gnt), 32'h1);

    // Move to a write grant, then send a stray read done.
    rd_req = 1'b0; rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    tick();
    tick();
    chk("to_wr_gnt", 32'(wr_gnt), 32'h1);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    chk("stray_wr_gnt", 32'(wr_gnt), 32'h1);
    chk("stray_rd_gnt", 32'(rd_gnt), 32'h0);
    tick();
    chk("stray_hold", 32'(wr_gnt), 32'h1);
    chk("stray_af_we", 32'(af_we), 32'h1);
    chk("stray_addr", 32'(address), 32'h200);

    // Asynchronous reset during a write burst.
    reset = 1'b0;
    #1;
    chk("arst_wr_gnt", 32'(wr_gnt), 32'h0);
    chk("arst_af_we", 32'(af_we), 32'h0);
    chk("arst_addr", 32'(address), 32'h0);
    tick();
    reset = 1'b1;
    tick();
    chk("arst_idle", 32'(wr_gnt), 32'h0);
    tick();
    chk("arst_regnt", 32'(wr_gnt), 32'h1);

    // Reads with no write waiting must not build up the run count.
    wr_req = 1'b0; rd_req = 1'b1;
    burst(1'b1, "rc_w");
    burst(1'b0, "rc0"); burst(1'b0, "rc1"); burst(1'b0, "rc2"); burst(1'b0, "rc3");
    wr_req = 1'b1;
    burst(1'b0, "rc4");
    chk("rc_bias", 32'(rd_gnt), 32'h1);

    // Calibration lost while owning: finish, then wait for calibration again.
    wr_req = 1'b0; phy_init_done = 1'b0; rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    chk("phy_turn", 32'({wr_gnt, rd_gnt}), 32'h0);
    tick();
    tick();
    tick();
    chk("phy_hold", 32'(rd_gnt), 32'h0);
    phy_init_done = 1'b1;
    tick();
    chk("phy_idle", 32'(rd_gnt), 32'h0);
    tick();
    chk("phy_regnt", 32'(rd_gnt), 32'h1);
    chk("final_err", 32'(sched_err), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
